slot_spin_controller: RTL and testbench
=======================================

# slot_spin_controller

Sequencer for the three slot-machine reels. Each reel is an LFSR reel module with its own `run` and synchronous `reset` (seed load) inputs. This block handles the player's start and stop buttons, enforces minimum and maximum spin times, and stops the reels one after another with a fixed stagger. Once all reels are still it latches the three reel values and classifies the result (none / pair / jackpot / lucky-seven) for the display and payout logic.

## Interface
- `SPIN_MIN`, default 8: minimum SPIN cycles before `stop` is honoured; must be ≥1 and < `SPIN_MAX`.
- `SPIN_MAX`, default 64: SPIN cycles after which the reels auto-stop; must be ≤255.
- `STAGGER`, default 4: cycles between successive reel stops; must be ≥1 and ≤255.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears every register.
- `start` in 1: level sampled each cycle; request a new game.
- `stop` in 1: level sampled each cycle; player stop request.
- `reel0`, `reel1`, `reel2` in 4 each: current `number` outputs of the reels.
- `reel_run` out 3: per-reel `run` drive; bit i drives reel i.
- `reel_load` out 1: drives every reel's `reset` (seed load).
- `busy` out 1: high in LOAD, SPIN, STOP, EVAL.
- `done` out 1: high in SHOW.
- `result0`, `result1`, `result2` out 4 each: latched reel values.
- `payout` out 2: 0 none, 1 pair, 2 jackpot, 3 lucky seven.

## Operation
- States:
  - IDLE: all outputs 0.
  - LOAD: `reel_load`=1, `reel_run`=000.
  - SPIN: `reel_run`=111.
  - STOP: staggered stop, using sub-phase counter `ph` (0/1) and cycle counter `cnt`.
  - EVAL: `reel_run`=000.
  - SHOW: `done`=1.
- Transitions:
  - IDLE or SHOW with `start`=1 → LOAD. Leaving SHOW keeps `result*` and `payout` until the next EVAL.
  - LOAD → SPIN unconditionally after 1 cycle. `cnt` is cleared on SPIN entry.
  - SPIN: `cnt` increments each cycle.
    - `stop`=1 with `cnt`≥`SPIN_MIN` → STOP.
    - Otherwise `cnt`==`SPIN_MAX`-1 → STOP (auto).
    - `cnt` is cleared on exit.
  - STOP, `ph`=0: `reel_run`=110 for `STAGGER` cycles, then `ph`=1 and `cnt`=0.
  - STOP, `ph`=1: `reel_run`=100 for `STAGGER` cycles, then → EVAL.
  - EVAL: 1 cycle. At its closing edge, `result0..2` ← `reel0..2` and `payout` is computed; → SHOW.
  - SHOW: hold until `start`.
- Payout classification:
  - All three equal and value 4'h7 → 3.
  - All three equal, any other value → 2.
  - Exactly two equal → 1.
  - Otherwise → 0.
- Ignored inputs:
  - `start` in LOAD/SPIN/STOP/EVAL.
  - `stop` outside SPIN.
  - `start` and `stop` together in IDLE/SHOW: start is taken, stop has no effect.
- Counters are 8 bits, never wrap (bounded by parameters), and compare unsigned.
- `reel_load` and `reel_run` are never high together. Reels give `run` priority, so LOAD must have `run`=000.

## Timing
- All outputs are registered. Reset value is 0 for `reel_run`, `reel_load`, `busy`, `done`, `result*`, `payout`.
- `start` sampled at edge E: LOAD during E+1, SPIN from E+2.
- SPIN length:
  - `stop` held high from the start of SPIN → exactly `SPIN_MIN`+1 cycles.
  - No `stop` → exactly `SPIN_MAX` cycles.
- From the last SPIN cycle:
  - `reel_run`=110 for `STAGGER` cycles.
  - then 100 for `STAGGER` cycles.
  - then EVAL for 1 cycle.
  - then `done` rises.
- Reel values are stable in EVAL: each reel updates `number` only on edges with run=1, and its last run edge precedes EVAL.
- Asynchronous `reset` mid-game: outputs go to 0 immediately without waiting for a clock. First active edge after deassertion is in IDLE.

## Test plan
- Reset, then hold `start`=0 for 10 cycles → all outputs 0, `busy`=0, `done`=0.
- Defaults; `start` pulse at edge 0; `stop` held high → LOAD at cycle 1, `reel_run`=111 for cycles 2–10, 110 for 11–14, 100 for 15–18, EVAL at 19, `done`=1 from cycle 20.
- `stop` pulse at SPIN `cnt`=3 only → ignored; auto-stop after 64 SPIN cycles; `reel_run` drops to 110 exactly 64 cycles after SPIN entry.
- Reel values forced at EVAL:
  - 7,7,7 → `payout`=3.
  - 5,5,5 → 2.
  - 5,9,5 → 1.
  - 1,2,3 → 0.
  - `result*` match the forced values in each case.
- `reset` asserted mid-SPIN between edges → `reel_run`=000 immediately. After release, `start` gives a full sequence with LOAD first.
- `start` pulses during SPIN and STOP, `stop` pulses in IDLE/SHOW → no state change. `start`+`stop` together in SHOW → LOAD next cycle, prior results retained until EVAL.

Source files
------------

// File: rtl/slot_spin_controller.sv
// slot_spin_controller: sequences three LFSR reels through load, spin,
// staggered stop and evaluation, then latches and classifies the result.
module slot_spin_controller #(
  parameter int SPIN_MIN = 8,
  parameter int SPIN_MAX = 64,
  parameter int STAGGER  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] reel0,
  input  logic [3:0] reel1,
  input  logic [3:0] reel2,
  output logic [2:0] reel_run,
  output logic       reel_load,
  output logic       busy,
  output logic       done,
  output logic [3:0] result0,
  output logic [3:0] result1,
  output logic [3:0] result2,
  output logic [1:0] payout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SPIN,
    STOP,
    EVAL,
    SHOW
  } state_t;

  localparam logic [7:0] SPIN_MIN_C  = 8'(SPIN_MIN);
  localparam logic [7:0] SPIN_LAST_C = 8'(SPIN_MAX - 1);
  localparam logic [7:0] STAG_LAST_C = 8'(STAGGER - 1);

  state_t     state, next_state;
  logic       ph, next_ph;
  logic [7:0] cnt, next_cnt;

  logic [2:0] next_reel_run;
  logic       next_reel_load;
  logic       next_busy;
  logic       next_done;

  // Result classification: lucky seven beats jackpot beats pair.
  function automatic logic [1:0] classify(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [3:0] c);
    logic e01, e12, e02;
    e01 = (a == b);
    e12 = (b == c);
    e02 = (a == c);
    if (e01 && e12)
      classify = (a == 4'h7) ? 2'd3 : 2'd2;
    else if (e01 || e12 || e02)
      classify = 2'd1;
    else
      classify = 2'd0;
  endfunction

  // State, sub-phase and cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ph    <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      ph    <= next_ph;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: spin timing, stop qualification and stagger phases.
  always_comb begin
    next_state = state;
    next_ph    = ph;
    next_cnt   = cnt;
    case (state)
      IDLE, SHOW: begin
        if (start) begin
          next_state = LOAD;
          next_ph    = 1'b0;
          next_cnt   = 8'd0;
        end
      end
      LOAD: begin
        next_state = SPIN;
        next_cnt   = 8'd0;
      end
      SPIN: begin
        if ((stop && (cnt >= SPIN_MIN_C)) || (cnt == SPIN_LAST_C)) begin
          next_state = STOP;
          next_ph    = 1'b0;
          next_cnt   = 8'd0;
        end else begin
          next_cnt = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == STAG_LAST_C) begin
          next_cnt = 8'd0;
          if (!ph) begin
            next_ph = 1'b1;
          end else begin
            next_ph    = 1'b0;
            next_state = EVAL;
          end
        end else begin
          next_cnt = cnt + 8'd1;
        end
      end
      EVAL: begin
        next_state = SHOW;
      end
      default: begin
        next_state = IDLE;
        next_ph    = 1'b0;
        next_cnt   = 8'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  // and still line up with the state they belong to.
  always_comb begin
    next_reel_run  = 3'b000;
    next_reel_load = 1'b0;
    next_busy      = 1'b0;
    next_done      = 1'b0;
    case (next_state)
      LOAD: begin
        next_reel_load = 1'b1;
        next_busy      = 1'b1;
      end
      SPIN: begin
        next_reel_run = 3'b111;
        next_busy     = 1'b1;
      end
      STOP: begin
        next_reel_run = next_ph ? 3'b100 : 3'b110;
        next_busy     = 1'b1;
      end
      EVAL: begin
        next_busy = 1'b1;
      end
      SHOW: begin
        next_done = 1'b1;
      end
      default: begin
        next_reel_run = 3'b000;
      end
    endcase
  end

  // Registered control outputs; run and load are mutually exclusive by decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reel_run  <= 3'b000;
      reel_load <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      reel_run  <= next_reel_run;
      reel_load <= next_reel_load;
      busy      <= next_busy;
      done      <= next_done;
    end
  end

  // Latch reel values and payout at the closing edge of EVAL only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result0 <= 4'd0;
      result1 <= 4'd0;
      result2 <= 4'd0;
      payout  <= 2'd0;
    end else if (state == EVAL) begin
      result0 <= reel0;
      result1 <= reel1;
      result2 <= reel2;
      payout  <= classify(reel0, reel1, reel2);
    end
  end

endmodule

// File: tb/tb_slot_spin_controller.sv
// tb_slot_spin_controller: directed game sequences with a result scoreboard.
module tb_slot_spin_controller;

  localparam int SPIN_MIN = 8;
  localparam int SPIN_MAX = 64;
  localparam int STAGGER  = 4;

  typedef struct packed {
    logic [3:0] r0;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [1:0] pay;
  } result_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] reel0 = 4'd0;
  logic [3:0] reel1 = 4'd0;
  logic [3:0] reel2 = 4'd0;
  logic [2:0] reel_run;
  logic       reel_load;
  logic       busy;
  logic       done;
  logic [3:0] result0;
  logic [3:0] result1;
  logic [3:0] result2;
  logic [1:0] payout;

  int      checks = 0;
  int      fails  = 0;
  result_t sb_q[$];
  result_t prev_res = '0;

  slot_spin_controller #(
    .SPIN_MIN(SPIN_MIN),
    .SPIN_MAX(SPIN_MAX),
    .STAGGER (STAGGER)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .reel0    (reel0),
    .reel1    (reel1),
    .reel2    (reel2),
    .reel_run (reel_run),
    .reel_load(reel_load),
    .busy     (busy),
    .done     (done),
    .result0  (result0),
    .result1  (result1),
    .result2  (result2),
    .payout   (payout)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  // Reference payout: count equal pairs among the three reels.
  function automatic logic [1:0] ref_payout(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    int pairs;
    pairs = int'(a == b) + int'(b == c) + int'(a == c);
    if (pairs == 3) return (a == 4'h7) ? 2'd3 : 2'd2;
    if (pairs == 1) return 2'd1;
    return 2'd0;
  endfunction

  // Expected {reel_load, reel_run, busy, done} for game cycle c (cycle 1 = LOAD).
  function automatic logic [5:0] exp_ctrl(input int c, input int spin_len);
    if (c == 1)                                 return {1'b1, 3'b000, 1'b1, 1'b0};
    if (c <= 1 + spin_len)                      return {1'b0, 3'b111, 1'b1, 1'b0};
    if (c <= 1 + spin_len + STAGGER)            return {1'b0, 3'b110, 1'b1, 1'b0};
    if (c <= 1 + spin_len + 2 * STAGGER)        return {1'b0, 3'b100, 1'b1, 1'b0};
    if (c == 2 + spin_len + 2 * STAGGER)        return {1'b0, 3'b000, 1'b1, 1'b0};
    return {1'b0, 3'b000, 1'b0, 1'b1};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ctrl"}, 16'({reel_load, reel_run, busy, done}), 16'h0);
  endtask

  task automatic checkResults(input string tag, input result_t exp);
    checkOutput({tag, " result0"}, 16'(result0), 16'(exp.r0));
    checkOutput({tag, " result1"}, 16'(result1), 16'(exp.r1));
    checkOutput({tag, " result2"}, 16'(result2), 16'(exp.r2));
    checkOutput({tag, " payout"},  16'(payout),  16'(exp.pay));
  endtask

  // One full game from IDLE/SHOW; called at a falling edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c3,
                               input bit hold_stop, input int spin_len,
                               input int stop_pulse_c, input int start_pulse_c);
    int      total;
    result_t exp;
    reel0 = a;
    reel1 = b;
    reel2 = c3;
    sb_q.push_back({a, b, c3, ref_payout(a, b, c3)});
    start = 1'b1;
    stop  = hold_stop;
    step();
    start = 1'b0;
    total = 3 + spin_len + 2 * STAGGER;
    for (int c = 1; c <= total; c++) begin
      checkOutput($sformatf("ctrl c%0d", c), 16'({reel_load, reel_run, busy, done}),
                  16'(exp_ctrl(c, spin_len)));
      if (c < total) begin
        if (c == 1 || c == total - 1) checkResults($sformatf("held c%0d", c), prev_res);
        start = (c == start_pulse_c);
        stop  = hold_stop || (c == stop_pulse_c);
        step();
      end else if (sb_q.size() == 0) begin
        checkOutput("scoreboard empty", 16'd1, 16'd0);
      end else begin
        exp = sb_q.pop_front();
        checkResults("eval", exp);
        prev_res = exp;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Directed sequence of games, stray inputs and a mid-game reset.
  initial begin
    repeat (2) @(negedge clk);
    checkIdle("in reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checkIdle($sformatf("idle %0d", i));
    end
    checkResults("idle", '0);

    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    checkIdle("stop in idle");

    $display("[TB] game 1: stop held, 7-7-7");
    applyStimulus(4'h7, 4'h7, 4'h7, 1'b1, SPIN_MIN + 1, 0, 0);

    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    checkOutput("stop in show", 16'({busy, done}), 16'b01);

    $display("[TB] game 2: auto stop, stray start/stop, 5-5-5");
    applyStimulus(4'h5, 4'h5, 4'h5, 1'b0, SPIN_MAX, 5, 10);

    $display("[TB] game 3: start+stop in show, 5-9-5");
    applyStimulus(4'h5, 4'h9, 4'h5, 1'b1, SPIN_MIN + 1, 0, 2 + SPIN_MIN + 2);

    $display("[TB] game 4: 1-2-3");
    applyStimulus(4'h1, 4'h2, 4'h3, 1'b1, SPIN_MIN + 1, 0, 0);

    $display("[TB] mid-spin reset");
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checkOutput("pre-reset run", 16'(reel_run), 16'(3'b111));
    #2 reset = 1'b1;
    #1;
    checkIdle("async reset");
    checkResults("async reset", '0);
    @(negedge clk);
    reset = 1'b0;
    prev_res = '0;
    step();
    checkIdle("after reset");

    $display("[TB] game 5: after reset, 3-3-8");
    applyStimulus(4'h3, 4'h3, 4'h8, 1'b1, SPIN_MIN + 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
